inst_loader: RTL and testbench
==============================

# inst_loader

Instruction loader that writes 16-bit instruction words into the processor's instruction memory. It is the write side of the same memory that the fetch counter reads through the processor's `DIN` path. An operator enters each word as two bytes, high byte first, from the board switches, advancing one byte per key strobe. The block assembles the bytes, issues single-cycle write pulses at sequential addresses from 0, and reports progress, fill state and an optional checksum.

## Interface
- `DATA_W`, 16, instruction word width; must equal 2×8.
- `ADDR_W`, 5, memory address width; must match the fetch counter.
- `DEPTH`, 32, number of words; 2**ADDR_W.
- `Clock`  in  1  system clock; all state updates on its rising edge.
- `Resetn`  in  1  reset, asynchronous and active-low; one clock, no other reset source.
- `Start`  in  1  synchronous level; when high, the address restarts at 0 and the block enters load mode.
- `Stop`  in  1  synchronous level; ends loading and returns to idle.
- `Strobe`  in  1  asynchronous key level; synchronized internally, and each rising edge takes one byte.
- `Byte`  in  8  byte value, from switches.
- `WrEn`  out  1  memory write enable, exactly one cycle per word.
- `WrAddr`  out  ADDR_W  write address.
- `WrData`  out  DATA_W  write data, {high byte, low byte}.
- `Count`  out  ADDR_W+1  words written since the last Start, 0..DEPTH.
- `Loading`  out  1  high in states HIGH, LOW and WRITE.
- `WaitLow`  out  1  high in state LOW (high byte held).
- `Full`  out  1  high in state FULL.
- `Checksum`  out  DATA_W  running sum of written words (see Configuration).

## Operation
- **Strobe synchronizer:** two flops, `s1` then `s2`, plus a history flop `s3`. `strobe_rise = s2 & ~s3`.
- **States:** IDLE, HIGH, LOW, WRITE, FULL. State is registered. All outputs decode from registers; none are combinational from inputs.
- **IDLE / FULL:**
  - `Start` → HIGH, with addr=0, Count=0, Checksum=0.
  - Strobe edges are ignored.
- **HIGH:**
  - `strobe_rise` → hi←Byte, go to LOW.
  - `Stop` → IDLE.
- **LOW:**
  - `strobe_rise` → lo←Byte, go to WRITE.
  - `Stop` → IDLE, discarding hi.
- **WRITE** (exactly one cycle):
  - WrEn=1, WrAddr=addr, WrData={hi,lo}.
  - On exit: addr←addr+1 (wraps mod DEPTH), Count←Count+1, Checksum←Checksum+WrData (mod 2**DATA_W).
  - If Count+1==DEPTH → FULL, else → HIGH.
  - Start, Stop and strobe are ignored in WRITE, so the write always completes.
- **Priority in HIGH/LOW:** Start > Stop > strobe_rise.
  - Start re-enters HIGH with addr=0, Count=0, Checksum=0, and discards any held hi byte.
  - A strobe edge in the same cycle as Start or Stop is dropped.
- **Level inputs:** `Start` held high keeps re-entering HIGH at addr 0, so the bench or operator pulses it.
- **Write-only:** the block never reads memory. WrAddr holds the current addr in all states. WrData holds {hi,lo} from the last assembled word.

## Timing
- **Reset:** on `Resetn`=0, immediately and asynchronously: state=IDLE, s1=s2=s3=0, hi=lo=0, addr=0. All outputs then read WrEn=0, WrAddr=0, WrData=0, Count=0, Loading=0, WaitLow=0, Full=0, Checksum=0.
- **Reset mid-word:** reset during LOW or WRITE aborts without a write, even if WRITE was pending.
- **Byte latency:** if Strobe is first sampled high at edge k, then s2=1 after k+1 and the byte is captured at edge k+2. Byte must be stable over edges k..k+2.
- **Write latency:** the low-byte capture at edge n puts the block in WRITE during cycle n..n+1, with WrEn high for that one cycle. The memory samples at edge n+1. Count and WrAddr increment after edge n+1.
- **Strobe spacing:** strobe high/low phases must each be ≥1 Clock period. Shorter pulses may be missed; this is not an error.
- **Throughput:** the maximum rate is one word per 4 cycles (2 edges + WRITE + re-arm). Strobes arriving faster are dropped, not queued.

## Configuration
- **Macro:** `INST_LOADER_CHECKSUM_EN`.
- **Defined:** Checksum is a DATA_W register, updated in WRITE and cleared by Start and reset.
- **Undefined:** no checksum register is built; `Checksum` is tied to 0. All other behaviour is identical.

## Test plan
- **Reset:** reset, then Start, then strobe 0x12, 0x34 → one-cycle WrEn with WrAddr=0, WrData=0x1234; Count=1; Checksum=0x1234 with the macro, 0 without.
- **Fill:** load 32 words, word i = {i, ~i} → addresses 0..31 in order, Full=1, Count=32, Loading=0. A 33rd strobe produces no WrEn.
- **Stop in LOW:** high byte 0xAA, Stop, Start, then bytes 0x01, 0x02 → write of 0x0102 at addr 0; 0xAA never appears.
- **Start + strobe collision:** Start in the same cycle as `strobe_rise` in LOW → restart at HIGH, addr=0, and the strobe byte is discarded.
- **Reset mid-word:** assert Resetn=0 in the cycle before WRITE → no WrEn, and all outputs read zero immediately.
- **Bouncy strobe:** 1-cycle glitches and 4-cycle strobes → each stable strobe captured exactly once. Byte must be held through the capture edge.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: assembles 16-bit instruction words from two operator-entered bytes
// (high byte first, one byte per key strobe) and writes them to instruction
// memory at sequential addresses starting from 0.
//
// Optional feature: define INST_LOADER_CHECKSUM_EN to build a running checksum
// of written words. When it is undefined, Checksum is tied to 0.
module inst_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Strobe,
  input  logic [7:0]        Byte,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic [ADDR_W:0]   Count,
  output logic              Loading,
  output logic              WaitLow,
  output logic              Full,
  output logic [DATA_W-1:0] Checksum
);

  // Word count at which the memory is full.
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StHigh,
    StLow,
    StWrite,
    StFull
  } state_e;

  state_e state_q, state_d;

  // Strobe synchronizer and edge history.
  logic s1_q, s2_q, s3_q;
  logic strobe_rise;

  // Datapath registers.
  logic [7:0]        hi_q;
  logic [DATA_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;

  // Registered status outputs, always equal to a decode of state_q.
  logic wr_en_q;
  logic loading_q;
  logic wait_low_q;
  logic full_q;

  // Decoded control events for the current cycle.
  logic in_load;
  logic restart;
  logic stop_load;
  logic take_hi;
  logic take_lo;
  logic do_write;
  logic last_word;

  // Two-flop synchronizer for the asynchronous key level, plus history flop.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Strobe;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign strobe_rise = s2_q & ~s3_q;

  // Event decode: Start beats Stop beats strobe; WRITE ignores all three.
  always_comb begin
    in_load   = (state_q == StHigh) || (state_q == StLow);
    restart   = Start && (state_q != StWrite);
    stop_load = in_load && !Start && Stop;
    take_hi   = (state_q == StHigh) && !Start && !Stop && strobe_rise;
    take_lo   = (state_q == StLow) && !Start && !Stop && strobe_rise;
    do_write  = (state_q == StWrite);
    last_word = ((count_q + 1'b1) == DepthCnt);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StFull: begin
        if (Start) state_d = StHigh;
      end
      StHigh: begin
        if (Start)            state_d = StHigh;
        else if (Stop)        state_d = StIdle;
        else if (strobe_rise) state_d = StLow;
      end
      StLow: begin
        if (Start)            state_d = StHigh;
        else if (Stop)        state_d = StIdle;
        else if (strobe_rise) state_d = StWrite;
      end
      StWrite: begin
        state_d = last_word ? StFull : StHigh;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register, registered status outputs and word/address datapath.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      wr_en_q    <= 1'b0;
      loading_q  <= 1'b0;
      wait_low_q <= 1'b0;
      full_q     <= 1'b0;
      hi_q       <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= (state_d == StWrite);
      loading_q  <= (state_d == StHigh) || (state_d == StLow) || (state_d == StWrite);
      wait_low_q <= (state_d == StLow);
      full_q     <= (state_d == StFull);

      // A held high byte is dropped whenever loading is restarted or stopped.
      if (restart || stop_load) begin
        hi_q <= '0;
      end else if (take_hi) begin
        hi_q <= Byte;
      end

      // word_q keeps the last assembled word so WrData is stable between writes.
      if (take_lo) begin
        word_q <= {hi_q, Byte};
      end

      if (restart) begin
        addr_q  <= '0;
        count_q <= '0;
      end else if (do_write) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Running modular sum of every word written since the last Start.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      csum_q <= '0;
    end else if (restart) begin
      csum_q <= '0;
    end else if (do_write) begin
      csum_q <= csum_q + word_q;
    end
  end

  assign Checksum = csum_q;
`else
  assign Checksum = '0;
`endif

  assign WrEn    = wr_en_q;
  assign WrAddr  = addr_q;
  assign WrData  = word_q;
  assign Count   = count_q;
  assign Loading = loading_q;
  assign WaitLow = wait_low_q;
  assign Full    = full_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
module tb_inst_loader;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic        Stop;
  logic        Strobe;
  logic [7:0]  Byte;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [15:0] WrData;
  logic [5:0]  Count;
  logic        Loading;
  logic        WaitLow;
  logic        Full;
  logic [15:0] Checksum;

  int n_cmp  = 0;
  int n_fail = 0;

  // Every cycle with WrEn high, as seen at the falling edge.
  logic [4:0]  q_addr[$];
  logic [15:0] q_data[$];

  inst_loader #(
    .DATA_W(16),
    .ADDR_W(5),
    .DEPTH (32)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Start   (Start),
    .Stop    (Stop),
    .Strobe  (Strobe),
    .Byte    (Byte),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .Count   (Count),
    .Loading (Loading),
    .WaitLow (WaitLow),
    .Full    (Full),
    .Checksum(Checksum)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (WrEn === 1'b1) begin
      q_addr.push_back(WrAddr);
      q_data.push_back(WrData);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] csum_exp(input logic [15:0] v);
`ifdef INST_LOADER_CHECKSUM_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Stable two-cycle-high, two-cycle-low key press.
  task automatic press(input logic [7:0] b);
    Byte   = b;
    Strobe = 1'b1;
    tick();
    tick();
    Strobe = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    Start  = 1'b0;
    Stop   = 1'b0;
    Strobe = 1'b0;
    Byte   = 8'h00;
    tick();
    tick();
    n_cmp++;
    if ({WrEn, WrAddr, WrData, Count} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_datapath: got %b %h %h %0d required 0 00 0000 0",
               WrEn, WrAddr, WrData, Count);
    end
    n_cmp++;
    if ({Loading, WaitLow, Full, Checksum} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_status: got %b%b%b %h required 000 0000",
               Loading, WaitLow, Full, Checksum);
    end
    Resetn = 1'b1;
    tick();
    n_cmp++;
    if (Loading !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got Loading=%b required 0", Loading);
    end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    n_cmp++;
    if ({Loading, WaitLow, Count} !== {1'b1, 1'b0, 6'd0}) begin
      n_fail++;
      $display("FAIL basic_start: got Loading=%b WaitLow=%b Count=%0d required 1 0 0",
               Loading, WaitLow, Count);
    end
    press(8'h12);
    n_cmp++;
    if (WaitLow !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_waitlow: got %b required 1", WaitLow);
    end
    press(8'h34);
    n_cmp++;
    if (q_addr.size() != 1) begin
      n_fail++;
      $display("FAIL basic_pulses: got %0d WrEn cycles required 1", q_addr.size());
    end else begin
      n_cmp++;
      if ({q_addr[0], q_data[0]} !== {5'd0, 16'h1234}) begin
        n_fail++;
        $display("FAIL basic_write: got addr=%0d data=%h required 0 1234", q_addr[0], q_data[0]);
      end
    end
    n_cmp++;
    if ({Count, WrAddr, WrEn, WaitLow} !== {6'd1, 5'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_after: got Count=%0d WrAddr=%0d WrEn=%b WaitLow=%b required 1 1 0 0",
               Count, WrAddr, WrEn, WaitLow);
    end
    n_cmp++;
    if (Checksum !== csum_exp(16'h1234)) begin
      n_fail++;
      $display("FAIL basic_checksum: got %h required %h", Checksum, csum_exp(16'h1234));
    end
  endtask

  task automatic test_fill();
    logic [15:0] sum;
    logic [7:0]  b;
    int          bad;
    sum = 16'h0;
    bad = 0;
    clear_log();
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      b = i[7:0];
      press(b);
      press(~b);
      sum = sum + {b, ~b};
    end
    n_cmp++;
    if (q_addr.size() != 32) begin
      n_fail++;
      $display("FAIL fill_pulses: got %0d WrEn cycles required 32", q_addr.size());
    end
    for (int i = 0; i < 32 && i < q_addr.size(); i++) begin
      b = i[7:0];
      n_cmp++;
      if ({q_addr[i], q_data[i]} !== {i[4:0], b, ~b}) begin
        n_fail++;
        bad++;
        if (bad < 4)
          $display("FAIL fill_word%0d: got addr=%0d data=%h required %0d %h",
                   i, q_addr[i], q_data[i], i, {b, ~b});
      end
    end
    n_cmp++;
    if ({Full, Count, Loading, WrAddr} !== {1'b1, 6'd32, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL fill_state: got Full=%b Count=%0d Loading=%b WrAddr=%0d required 1 32 0 0",
               Full, Count, Loading, WrAddr);
    end
    n_cmp++;
    if (Checksum !== csum_exp(sum)) begin
      n_fail++;
      $display("FAIL fill_checksum: got %h required %h", Checksum, csum_exp(sum));
    end
    press(8'h55);
    press(8'h66);
    n_cmp++;
    if (q_addr.size() != 32 || Full !== 1'b1 || Count !== 6'd32) begin
      n_fail++;
      $display("FAIL fill_overflow: got %0d writes Full=%b Count=%0d required 32 1 32",
               q_addr.size(), Full, Count);
    end
  endtask

  task automatic test_stop_in_low();
    clear_log();
    pulse_start();
    press(8'hAA);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    n_cmp++;
    if ({Loading, WaitLow} !== 2'b00) begin
      n_fail++;
      $display("FAIL stop_idle: got Loading=%b WaitLow=%b required 0 0", Loading, WaitLow);
    end
    pulse_start();
    press(8'h01);
    press(8'h02);
    n_cmp++;
    if (q_addr.size() != 1) begin
      n_fail++;
      $display("FAIL stop_pulses: got %0d WrEn cycles required 1", q_addr.size());
    end else begin
      n_cmp++;
      if ({q_addr[0], q_data[0]} !== {5'd0, 16'h0102}) begin
        n_fail++;
        $display("FAIL stop_write: got addr=%0d data=%h required 0 0102", q_addr[0], q_data[0]);
      end
    end
    n_cmp++;
    if (Checksum !== csum_exp(16'h0102)) begin
      n_fail++;
      $display("FAIL stop_checksum: got %h required %h", Checksum, csum_exp(16'h0102));
    end
  endtask

  task automatic test_start_collision();
    clear_log();
    pulse_start();
    press(8'h11);
    press(8'h11);
    press(8'h22);
    // strobe_rise is true in the cycle after the second sampling edge; Start joins it.
    Byte   = 8'h33;
    Strobe = 1'b1;
    tick();
    tick();
    Start = 1'b1;
    tick();
    Start  = 1'b0;
    Strobe = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({Loading, WaitLow, Count, WrAddr} !== {1'b1, 1'b0, 6'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL collide_state: got Loading=%b WaitLow=%b Count=%0d WrAddr=%0d required 1 0 0 0",
               Loading, WaitLow, Count, WrAddr);
    end
    press(8'h44);
    press(8'h55);
    n_cmp++;
    if (q_addr.size() != 2) begin
      n_fail++;
      $display("FAIL collide_pulses: got %0d WrEn cycles required 2", q_addr.size());
    end else begin
      n_cmp++;
      if ({q_addr[1], q_data[1]} !== {5'd0, 16'h4455}) begin
        n_fail++;
        $display("FAIL collide_write: got addr=%0d data=%h required 0 4455", q_addr[1], q_data[1]);
      end
    end
    n_cmp++;
    if (Checksum !== csum_exp(16'h4455)) begin
      n_fail++;
      $display("FAIL collide_checksum: got %h required %h", Checksum, csum_exp(16'h4455));
    end
  endtask

  task automatic test_reset_mid_word();
    clear_log();
    pulse_start();
    press(8'h12);
    press(8'h21);
    press(8'h77);
    Byte   = 8'h88;
    Strobe = 1'b1;
    tick();
    tick();
    // The next edge would capture the low byte and enter WRITE.
    Resetn = 1'b0;
    #1;
    n_cmp++;
    if ({WrEn, WrAddr, WrData, Count, Loading, WaitLow, Full, Checksum} !== 47'h0) begin
      n_fail++;
      $display("FAIL midreset_async: got WrEn=%b WrAddr=%0d WrData=%h Count=%0d L=%b W=%b F=%b C=%h required all 0",
               WrEn, WrAddr, WrData, Count, Loading, WaitLow, Full, Checksum);
    end
    tick();
    tick();
    Strobe = 1'b0;
    tick();
    Resetn = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (q_addr.size() != 1 || WrEn !== 1'b0 || Count !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset_nowrite: got %0d WrEn cycles WrEn=%b Count=%0d required 1 0 0",
               q_addr.size(), WrEn, Count);
    end
  endtask

  task automatic test_bouncy_strobe();
    clear_log();
    pulse_start();
    // Four-cycle press with a dip that falls between two clock edges.
    Byte   = 8'hC3;
    Strobe = 1'b1;
    tick();
    #2 Strobe = 1'b0;
    #2 Strobe = 1'b1;
    tick();
    tick();
    tick();
    Strobe = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if ({WaitLow, Loading} !== 2'b11) begin
      n_fail++;
      $display("FAIL bouncy_first: got WaitLow=%b Loading=%b required 1 1", WaitLow, Loading);
    end
    // A glitch entirely between edges is never sampled.
    Byte = 8'hEE;
    #2 Strobe = 1'b1;
    #3 Strobe = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (q_addr.size() != 0 || WaitLow !== 1'b1) begin
      n_fail++;
      $display("FAIL bouncy_glitch: got %0d writes WaitLow=%b required 0 1", q_addr.size(), WaitLow);
    end
    Byte   = 8'h3C;
    Strobe = 1'b1;
    repeat (4) tick();
    Strobe = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (q_addr.size() != 1) begin
      n_fail++;
      $display("FAIL bouncy_pulses: got %0d WrEn cycles required 1", q_addr.size());
    end else begin
      n_cmp++;
      if ({q_addr[0], q_data[0]} !== {5'd0, 16'hC33C}) begin
        n_fail++;
        $display("FAIL bouncy_write: got addr=%0d data=%h required 0 c33c", q_addr[0], q_data[0]);
      end
    end
    n_cmp++;
    if ({Count, WaitLow} !== {6'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL bouncy_count: got Count=%0d WaitLow=%b required 1 0", Count, WaitLow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_stop_in_low();
    test_start_collision();
    test_reset_mid_word();
    test_bouncy_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
